uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 16 +
 rtl/byte_fifo.sv | 54 +++++
 rtl/uart_tx.sv | 160 ++++++++++++++++
 tb/tb_uart_tx.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and frame geometry.
// Used by both the transmitter and the receiver.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS = 8;
    localparam int unsigned UART_STOP_BITS = 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO with first-word-fall-through read; pointers wrap modulo DEPTH.
// Push is ignored when full and pop is ignored when empty.
module byte_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  logic                        pop,
    input  logic [UART_DATA_BITS-1:0]   din,
    output logic [UART_DATA_BITS-1:0]   dout,
    output logic [$clog2(DEPTH):0]      count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [UART_DATA_BITS-1:0] mem_q [DEPTH];
    logic [AW-1:0]             wr_q;
    logic [AW-1:0]             rd_q;
    logic [CW-1:0]             cnt_q;
    logic                      do_push;
    logic                      do_pop;

    assign do_push = push && (cnt_q != CW'(DEPTH));
    assign do_pop  = pop && (cnt_q != '0);

    // Pointers and occupancy; simultaneous push and pop leave count unchanged.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din;
    end

    assign dout  = mem_q[rd_q];
    assign count = cnt_q;

endmodule

// File: rtl/uart_tx.sv
// Buffered UART transmitter: byte FIFO feeding a start/data/stop framer.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          txd,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned BW = $clog2(CLK_PER_BIT);

    uart_state_e               state_q, state_d;
    logic [BW-1:0]             baud_q, baud_d;
    logic [2:0]                bit_q, bit_d;
    logic [UART_DATA_BITS-1:0] sh_q, sh_d;
    logic                      txd_q, txd_d;
    logic                      bit_done;
    logic                      start_frame;
    logic                      pop_c;
    logic                      fifo_empty;
    logic [UART_DATA_BITS-1:0] fifo_dout;
`ifdef UART_TX_PARITY_EN
    logic                      par_q, par_d;
`endif

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid && in_ready),
        .pop   (pop_c),
        .din   (in_data),
        .dout  (fifo_dout),
        .count (fifo_count)
    );

    assign fifo_empty = (fifo_count == '0);
    assign in_ready   = (fifo_count != CW'(FIFO_DEPTH));
    assign busy       = (state_q != IDLE) || !fifo_empty;
    assign txd        = txd_q;
    assign bit_done   = (baud_q == BW'(CLK_PER_BIT - 1));

    // State register and framer datapath.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            txd_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            txd_q   <= txd_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Next-state logic; the baud counter is zeroed on every state entry.
    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q + BW'(1);
        bit_d       = bit_q;
        sh_d        = sh_q;
        pop_c       = 1'b0;
        start_frame = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d       = par_q;
`endif
        case (state_q)
            IDLE: begin
                baud_d      = '0;
                start_frame = !fifo_empty;
            end
            START: begin
                if (bit_done) begin
                    baud_d  = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_done) begin
                    baud_d = '0;
                    if (bit_q == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                        sh_d  = {1'b0, sh_q[UART_DATA_BITS-1:1]};
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_done) begin
                    baud_d  = '0;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_done) begin
                    baud_d      = '0;
                    state_d     = IDLE;
                    start_frame = !fifo_empty;
                end
            end
            default: begin
                baud_d  = '0;
                state_d = IDLE;
            end
        endcase
        // Pop the head byte and begin a frame without an idle cycle.
        if (start_frame) begin
            pop_c   = 1'b1;
            sh_d    = fifo_dout;
            bit_d   = '0;
            baud_d  = '0;
            state_d = START;
`ifdef UART_TX_PARITY_EN
            par_d   = ^fifo_dout;
`endif
        end
    end

    // Line level for the state being entered, so txd is registered with it.
    always_comb begin
        txd_d = 1'b1;
        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = sh_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  txd_d = par_d;
`endif
            default: txd_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed and randomized checks of uart_tx against a bit-period waveform model.
// Honours UART_TX_PARITY_EN for the expected frame length and parity bit.
module tb_uart_tx;

    localparam int CPB   = 5;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = CPB * NBITS;

    typedef logic [7:0] bq_t [$];

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       txd;
    logic       busy;
    logic [2:0] fifo_count;

    int checks   = 0;
    int failures = 0;

    uart_tx #(
        .CLK_PER_BIT (CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .txd        (txd),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Expected line level at sample idx of a frame carrying byte b.
    function automatic logic exp_bit(input logic [7:0] b, input int idx);
        int bit_n;
        bit_n = idx / CPB;
        if (bit_n == 0) return 1'b0;
        if (bit_n <= 8) return b[bit_n-1];
`ifdef UART_TX_PARITY_EN
        if (bit_n == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // Checks every cycle of a frame. done_n>0 means that many samples were already seen.
    task automatic expect_frame(input logic [7:0] b, input int done_n, input logic end_push,
                                input logic [7:0] end_byte, output int waited);
        int first;
        first  = done_n;
        waited = 0;
        if (done_n == 0) begin
            while (txd !== 1'b0 && waited < 400) begin
                @(negedge clk);
                waited++;
            end
            if (txd !== 1'b0) begin
                chk("start_seen", 32'(txd), 32'(0));
                return;
            end
            first = 1;
        end
        for (int i = first; i < FRAME; i++) begin
            @(negedge clk);
            chk($sformatf("frame_%02h_s%0d", b, i), 32'(txd), 32'(exp_bit(b, i)));
            if (i == FRAME - 1 && end_push) begin
                in_valid = 1'b1;
                in_data  = end_byte;
            end
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // One byte from idle: start bit appears one cycle after the push edge.
    task automatic send_single(input logic [7:0] b);
        int w;
        push_byte(b);
        chk("lat_txd_high", 32'(txd), 32'(1));
        chk("lat_count", 32'(fifo_count), 32'(1));
        chk("lat_busy", 32'(busy), 32'(1));
        expect_frame(b, 0, 1'b0, 8'h00, w);
        chk("lat_start", 32'(w), 32'(1));
        @(negedge clk);
        chk("single_busy_done", 32'(busy), 32'(0));
        chk("single_txd_idle", 32'(txd), 32'(1));
        chk("single_count", 32'(fifo_count), 32'(0));
    endtask

    // Holds in_valid for v.size() cycles from idle; returns the bytes the model accepts.
    task automatic burst(input bq_t v, output bq_t acc);
        int   m_cnt;
        logic rdy;
        m_cnt    = 0;
        acc      = {};
        in_valid = 1'b1;
        foreach (v[k]) begin
            in_data = v[k];
            rdy     = (m_cnt != DEPTH);
            chk($sformatf("burst_ready_%0d", k), 32'(in_ready), 32'(rdy));
            if (rdy) acc.push_back(v[k]);
            @(negedge clk);
            m_cnt = m_cnt + int'(rdy) - ((k == 1) ? 1 : 0);
            chk($sformatf("burst_count_%0d", k), 32'(fifo_count), 32'(m_cnt));
            chk($sformatf("burst_txd_%0d", k), 32'(txd), 32'((k == 0) ? 1 : 0));
        end
        in_valid = 1'b0;
    endtask

    task automatic idle_quiet(input string tag, input int cycles);
        int lows;
        lows = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (txd !== 1'b1) lows++;
        end
        chk(tag, 32'(lows), 32'(0));
        chk({tag, "_busy"}, 32'(busy), 32'(0));
    endtask

    initial begin
        bq_t v;
        bq_t acc;
        int  w;
        logic [7:0] x;

        repeat (2) @(negedge clk);
        chk("rst_txd", 32'(txd), 32'(1));
        chk("rst_ready", 32'(in_ready), 32'(1));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_count", 32'(fifo_count), 32'(0));
        rst = 1'b1;
        idle_quiet("idle_after_rst", 5);

        // Single byte 0x03, then a few random bytes.
        send_single(8'h03);
        repeat (3) send_single(8'($urandom));

        // Back-to-back frames with no gap.
        v = '{8'h01, 8'h02, 8'h03, 8'h04};
        burst(v, acc);
        expect_frame(acc[0], v.size() - 1, 1'b0, 8'h00, w);
        for (int i = 1; i < acc.size(); i++) begin
            expect_frame(acc[i], 0, 1'b0, 8'h00, w);
            chk($sformatf("b2b_gap_%0d", i), 32'(w), 32'(1));
        end
        idle_quiet("b2b_done", 2 * FRAME);

        // Full FIFO: ten cycles of in_valid, only the first five accepted.
        v = {};
        repeat (10) v.push_back(8'($urandom));
        burst(v, acc);
        expect_frame(acc[0], v.size() - 1, 1'b0, 8'h00, w);
        for (int i = 1; i < acc.size(); i++) begin
            expect_frame(acc[i], 0, 1'b0, 8'h00, w);
            chk($sformatf("full_gap_%0d", i), 32'(w), 32'(1));
        end
        idle_quiet("full_no_dup", 2 * FRAME);

        // Push and pop on the same edge at the end of STOP with two queued.
        v = {};
        repeat (3) v.push_back(8'($urandom));
        x = 8'($urandom);
        burst(v, acc);
        expect_frame(acc[0], v.size() - 1, 1'b1, x, w);
        @(negedge clk);
        in_valid = 1'b0;
        chk("pp_count", 32'(fifo_count), 32'(2));
        chk("pp_start", 32'(txd), 32'(0));
        expect_frame(acc[1], 1, 1'b0, 8'h00, w);
        expect_frame(acc[2], 0, 1'b0, 8'h00, w);
        chk("pp_gap_c", 32'(w), 32'(1));
        expect_frame(x, 0, 1'b0, 8'h00, w);
        chk("pp_gap_x", 32'(w), 32'(1));
        idle_quiet("pp_done", FRAME);

        // Parity-relevant bytes (frame length and parity bit follow the build).
        send_single(8'h07);
        send_single(8'h03);

        // Reset in the middle of data bit 3 with a second byte queued.
        v = {};
        repeat (2) v.push_back(8'($urandom));
        burst(v, acc);
        repeat (CPB * 4 + 2) @(negedge clk);
        chk("rst_mid_bit3", 32'(txd), 32'(exp_bit(acc[0], CPB * 4 + 2)));
        chk("rst_mid_count", 32'(fifo_count), 32'(1));
        rst = 1'b0;
        #1;
        chk("rst_mid_txd", 32'(txd), 32'(1));
        chk("rst_mid_count0", 32'(fifo_count), 32'(0));
        chk("rst_mid_ready", 32'(in_ready), 32'(1));
        chk("rst_mid_busy", 32'(busy), 32'(0));
        @(negedge clk);
        rst = 1'b1;
        idle_quiet("rst_no_start", 2 * FRAME);
        send_single(8'($urandom));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
